btb_assoc_predictor: RTL and testbench
======================================

Name: btb_assoc_predictor

Overview:
- Parametrised successor to the direct-mapped fetch-stage BTB.
- Set-associative branch target buffer: explicit valid bits, partial tags, configurable N-bit saturating counters and per-set round-robin replacement.
- Sits beside the fetch PC register. Predicts the next PC combinationally from current_PC and is trained by the resolving stage through a single update port. A synchronous flush port invalidates it on context change or fence.i.

Parameters:
- WORD_W, 32, PC/target width.
- SETS, 16, number of sets; power of 2, ≥2. IDX_W = $clog2(SETS).
- WAYS, 2, associativity; ≥1. WAY_W = max(1, $clog2(WAYS)).
- CNT_W, 2, saturating counter width; ≥1.
- TAG_W, 26, stored tag bits; 1 ≤ TAG_W ≤ WORD_W-2-IDX_W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- current_PC  in  WORD_W  fetch PC to predict.
- predicted_PC  out  WORD_W  next fetch PC.
- pred_hit  out  1  valid tag match for current_PC.
- pred_taken  out  1  hit and counter MSB = 1.
- pred_way  out  WAY_W  matching way; 0 when no hit.
- Wr_enable  in  1  update strobe, one resolved branch per cycle.
- update_PC  in  WORD_W  PC of resolved branch.
- update_target_PC  in  WORD_W  resolved target.
- is_taken  in  1  resolved direction.
- flush  in  1  invalidate all entries.

Behaviour:
- Address split: index = PC[IDX_W+1:2]; tag = PC[IDX_W+2+TAG_W-1 : IDX_W+2]. PC[1:0] is ignored.
- Lookup is purely combinational with zero latency:
  - hit = OR over ways of (valid & tag match); on multiple matches the lowest way wins.
  - pred_taken = hit & cnt[CNT_W-1].
  - predicted_PC = pred_taken ? target : current_PC+4, with the add truncated to WORD_W (wraps).
- No read-after-write bypass. A lookup in the same cycle as an update to the same entry sees pre-update state; the update is visible the next cycle.
- Update when Wr_enable=1 and flush=0, evaluated against the update_PC set:
  - Hit, is_taken=1: cnt saturating increment (max 2^CNT_W-1); target <= update_target_PC.
  - Hit, is_taken=0: cnt saturating decrement (min 0); target unchanged.
  - Hit in either direction: replacement pointer unchanged.
  - Miss, is_taken=1: allocate. Victim is the lowest-index invalid way, else the set's round-robin pointer, which then advances by 1 mod WAYS. The pointer advances only when a valid entry is evicted. On allocate: valid <= 1, tag, target <= update_target_PC, cnt <= 2^(CNT_W-1) (weakly taken).
  - Miss, is_taken=0: no allocation, no state change.
- Flush: on the rising edge with flush=1, all valid bits <= 0 and all round-robin pointers <= 0. Flush has priority over a coincident Wr_enable; that update is dropped. Tags, targets and counters are not cleared.
- Reset (nRST=0, asynchronous): all valid, tags, targets, counters and pointers <= 0. Output values immediately after reset: pred_hit=0, pred_taken=0, pred_way=0, predicted_PC=current_PC+4.
- Reset asserted mid-update: the update is lost and the state is fully cleared.
- Degenerate parameters:
  - WAYS=1: behaves as a direct-mapped BTB with valid bits; pred_way is always 0 and there is no pointer state.
  - CNT_W=1: allocate value is 1; a single not-taken clears it.
- Partial tags make aliasing legal: distinct PCs equal in the index and tag bits share an entry.

Test Plan (defaults SETS=16, WAYS=2, CNT_W=2, TAG_W=26):
- Reset, current_PC=0x100 -> predicted_PC=0x104, pred_hit=0, pred_taken=0, pred_way=0.
- Update 0x100→0x200 taken; next cycle current_PC=0x100 -> pred_hit=1, pred_taken=1, predicted_PC=0x200, cnt=2. Then one not-taken update -> cnt=1, predicted_PC=0x104, pred_hit=1, pred_taken=0.
- Saturation: from cnt=1, three taken updates -> cnt=3 (clamped). One not-taken -> cnt=2, still predicts 0x200. A same-cycle lookup during an update sees the old cnt.
- Conflict in set 0: allocate 0x100 (way 0), then 0x140 (way 1), then 0x180 -> evicts way 0 and pointer becomes 1. Afterwards 0x100 misses, 0x140 hits with pred_way=1, 0x180 hits with pred_way=0. Allocate 0x1C0 -> evicts way 1.
- Not-taken miss: update 0x300 with is_taken=0 -> the next lookup of 0x300 gives pred_hit=0 and predicted_PC=0x304.
- Flush with a coincident Wr_enable (0x400 taken): next cycle every previously trained PC and 0x400 miss. Re-training 0x100 afterwards allocates into way 0.

Source files
------------

// File: rtl/btb_assoc_predictor_if.sv
// Fetch-side bundle of the set-associative BTB: lookup (current_PC -> prediction)
// and the single training/flush port driven by the resolving stage.
interface btb_assoc_predictor_if #(
   parameter int WORD_W = 32,
   parameter int WAYS   = 2
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [WORD_W-1:0] current_PC;
   logic [WORD_W-1:0] predicted_PC;
   logic              pred_hit;
   logic              pred_taken;
   logic [WAY_W-1:0]  pred_way;
   logic              Wr_enable;
   logic [WORD_W-1:0] update_PC;
   logic [WORD_W-1:0] update_target_PC;
   logic              is_taken;
   logic              flush;

   modport master (
      output current_PC, Wr_enable, update_PC, update_target_PC, is_taken, flush,
      input  predicted_PC, pred_hit, pred_taken, pred_way
   );

   modport slave (
      input  current_PC, Wr_enable, update_PC, update_target_PC, is_taken, flush,
      output predicted_PC, pred_hit, pred_taken, pred_way
   );
endinterface

// File: rtl/btb_assoc_predictor.sv
// Set-associative branch target buffer with partial tags, saturating counters
// and per-set round-robin replacement; zero-latency lookup, one update per cycle.
module btb_assoc_predictor #(
   parameter int WORD_W = 32,
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int CNT_W  = 2,
   parameter int TAG_W  = 26
) (
   input  logic                 CLK,
   input  logic                 nRST,
   btb_assoc_predictor_if.slave bus
);
   localparam int IDX_W  = $clog2(SETS);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_LO = IDX_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1 << (CNT_W - 1));

   logic [WAYS-1:0]   r_valid  [SETS];
   logic [TAG_W-1:0]  r_tag    [SETS][WAYS];
   logic [WORD_W-1:0] r_target [SETS][WAYS];
   logic [CNT_W-1:0]  r_cnt    [SETS][WAYS];
   logic [WAY_W-1:0]  r_rrPtr  [SETS];

   logic [IDX_W-1:0]  w_rdIdx;
   logic [TAG_W-1:0]  w_rdTag;
   logic              w_rdHit;
   logic [WAY_W-1:0]  w_rdWay;
   logic              w_rdTaken;

   logic [IDX_W-1:0]  w_upIdx;
   logic [TAG_W-1:0]  w_upTag;
   logic              w_upHit;
   logic [WAY_W-1:0]  w_upWay;
   logic              w_freeFound;
   logic [WAY_W-1:0]  w_freeWay;
   logic [WAY_W-1:0]  w_victim;
   logic [WAY_W-1:0]  w_ptrNext;
   logic [CNT_W-1:0]  w_cntOld;
   logic [CNT_W-1:0]  w_cntNext;

   assign w_rdIdx = bus.current_PC[TAG_LO-1:2];
   assign w_rdTag = bus.current_PC[TAG_LO+TAG_W-1:TAG_LO];
   assign w_upIdx = bus.update_PC[TAG_LO-1:2];
   assign w_upTag = bus.update_PC[TAG_LO+TAG_W-1:TAG_LO];

   // Scanning from the top way down lets the lowest matching way win.
   always_comb begin
      w_rdHit = 1'b0;
      w_rdWay = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_rdIdx][w] && (r_tag[w_rdIdx][w] == w_rdTag)) begin
            w_rdHit = 1'b1;
            w_rdWay = WAY_W'(w);
         end
      end
   end

   assign w_rdTaken        = w_rdHit & r_cnt[w_rdIdx][w_rdWay][CNT_W-1];
   assign bus.pred_hit     = w_rdHit;
   assign bus.pred_taken   = w_rdTaken;
   assign bus.pred_way     = w_rdWay;
   assign bus.predicted_PC = w_rdTaken ? r_target[w_rdIdx][w_rdWay]
                                       : bus.current_PC + WORD_W'(4);

   always_comb begin
      w_upHit     = 1'b0;
      w_upWay     = '0;
      w_freeFound = 1'b0;
      w_freeWay   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_upIdx][w] && (r_tag[w_upIdx][w] == w_upTag)) begin
            w_upHit = 1'b1;
            w_upWay = WAY_W'(w);
         end
         if (!r_valid[w_upIdx][w]) begin
            w_freeFound = 1'b1;
            w_freeWay   = WAY_W'(w);
         end
      end
   end

   // Invalid ways are filled first; the pointer only moves when a live entry is evicted.
   assign w_victim  = w_freeFound ? w_freeWay : r_rrPtr[w_upIdx];
   assign w_ptrNext = (r_rrPtr[w_upIdx] == WAY_W'(WAYS - 1)) ? '0
                                                            : r_rrPtr[w_upIdx] + WAY_W'(1);

   assign w_cntOld  = r_cnt[w_upIdx][w_upWay];
   assign w_cntNext = bus.is_taken ? ((w_cntOld == CNT_MAX) ? w_cntOld : w_cntOld + CNT_W'(1))
                                   : ((w_cntOld == '0)      ? w_cntOld : w_cntOld - CNT_W'(1));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_rrPtr[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               r_tag[s][w]    <= '0;
               r_target[s][w] <= '0;
               r_cnt[s][w]    <= '0;
            end
         end
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_rrPtr[s] <= '0;
         end
      end else if (bus.Wr_enable) begin
         if (w_upHit) begin
            r_cnt[w_upIdx][w_upWay] <= w_cntNext;
            if (bus.is_taken) begin
               r_target[w_upIdx][w_upWay] <= bus.update_target_PC;
            end
         end else if (bus.is_taken) begin
            r_valid[w_upIdx][w_victim]  <= 1'b1;
            r_tag[w_upIdx][w_victim]    <= w_upTag;
            r_target[w_upIdx][w_victim] <= bus.update_target_PC;
            r_cnt[w_upIdx][w_victim]    <= CNT_INIT;
            if (!w_freeFound) begin
               r_rrPtr[w_upIdx] <= w_ptrNext;
            end
         end
      end
   end
endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Self-checking bench for btb_assoc_predictor: directed walk through the
// training/replacement/flush scenarios followed by randomized traffic vs. a reference model.
module tb_btb_assoc_predictor;
   localparam int WORD_W = 32;
   localparam int SETS   = 16;
   localparam int WAYS   = 2;
   localparam int CNT_W  = 2;
   localparam int TAG_W  = 26;
   localparam int IDX_W  = 4;
   localparam int CNT_TOP = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic nRST;

   always #5 CLK = ~CLK;

   btb_assoc_predictor_if #(.WORD_W(WORD_W), .WAYS(WAYS)) bus ();

   btb_assoc_predictor #(
      .WORD_W(WORD_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W), .TAG_W(TAG_W)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   int vectorCount = 0;
   int missCount   = 0;

   // Reference model: each set is a list of ways holding plain integers.
   bit          mValid  [SETS][WAYS];
   longint      mTag    [SETS][WAYS];
   logic [31:0] mTarget [SETS][WAYS];
   int          mCnt    [SETS][WAYS];
   int          mPtr    [SETS];

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> 2) % SETS);
   endfunction

   function automatic longint tagOf(input logic [31:0] pc);
      longint p;
      p = longint'(pc);
      return (p >> (IDX_W + 2)) & ((longint'(1) << TAG_W) - 1);
   endfunction

   task automatic modelReset();
      for (int s = 0; s < SETS; s++) begin
         mPtr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            mValid[s][w] = 0; mTag[s][w] = 0; mTarget[s][w] = '0; mCnt[s][w] = 0;
         end
      end
   endtask

   task automatic modelLookup(input logic [31:0] pc, output logic [31:0] nextPc,
                              output bit hit, output bit taken, output int way);
      int s;
      s = idxOf(pc);
      hit = 0; taken = 0; way = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && mValid[s][w] && mTag[s][w] == tagOf(pc)) begin
            hit = 1; way = w;
         end
      end
      if (hit && mCnt[s][way] >= (1 << (CNT_W - 1))) taken = 1;
      nextPc = taken ? mTarget[s][way] : pc + 32'd4;
   endtask

   task automatic modelClock();
      int s, way, victim;
      bit hit;
      if (bus.flush) begin
         for (int i = 0; i < SETS; i++) begin
            mPtr[i] = 0;
            for (int w = 0; w < WAYS; w++) mValid[i][w] = 0;
         end
         return;
      end
      if (!bus.Wr_enable) return;
      s = idxOf(bus.update_PC);
      hit = 0; way = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && mValid[s][w] && mTag[s][w] == tagOf(bus.update_PC)) begin
            hit = 1; way = w;
         end
      end
      if (hit) begin
         if (bus.is_taken) begin
            mCnt[s][way]    = (mCnt[s][way] + 1 > CNT_TOP) ? CNT_TOP : mCnt[s][way] + 1;
            mTarget[s][way] = bus.update_target_PC;
         end else begin
            mCnt[s][way] = (mCnt[s][way] - 1 < 0) ? 0 : mCnt[s][way] - 1;
         end
      end else if (bus.is_taken) begin
         victim = -1;
         for (int w = WAYS - 1; w >= 0; w--) if (!mValid[s][w]) victim = w;
         if (victim < 0) begin
            victim  = mPtr[s];
            mPtr[s] = (mPtr[s] + 1) % WAYS;
         end
         mValid[s][victim]  = 1;
         mTag[s][victim]    = tagOf(bus.update_PC);
         mTarget[s][victim] = bus.update_target_PC;
         mCnt[s][victim]    = 1 << (CNT_W - 1);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle's inputs and checks the combinational lookup against the model.
   task automatic applyStimulus(input logic [31:0] pc, input bit we, input logic [31:0] upc,
                                input logic [31:0] tgt, input bit tk, input bit fl);
      logic [31:0] expPc;
      bit          expHit, expTaken;
      int          expWay;
      @(negedge CLK);
      bus.current_PC       = pc;
      bus.Wr_enable        = we;
      bus.update_PC        = upc;
      bus.update_target_PC = tgt;
      bus.is_taken         = tk;
      bus.flush            = fl;
      #1;
      modelLookup(pc, expPc, expHit, expTaken, expWay);
      checkOutput("predicted_PC", bus.predicted_PC, expPc);
      checkOutput("pred_hit", 32'(bus.pred_hit), 32'(expHit));
      checkOutput("pred_taken", 32'(bus.pred_taken), 32'(expTaken));
      checkOutput("pred_way", 32'(bus.pred_way), 32'(expWay));
   endtask

   task automatic clockEdge();
      @(posedge CLK);
      if (nRST) modelClock();
   endtask

   task automatic step(input logic [31:0] pc, input bit we, input logic [31:0] upc,
                       input logic [31:0] tgt, input bit tk, input bit fl);
      applyStimulus(pc, we, upc, tgt, tk, fl);
      clockEdge();
   endtask

   // Lookup-only cycle with hand-derived expectations on top of the model check.
   task automatic probe(input logic [31:0] pc, input logic [31:0] expPc, input bit expHit,
                        input bit expTaken, input int expWay);
      applyStimulus(pc, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("probe_pc", bus.predicted_PC, expPc);
      checkOutput("probe_hit", 32'(bus.pred_hit), 32'(expHit));
      checkOutput("probe_taken", 32'(bus.pred_taken), 32'(expTaken));
      checkOutput("probe_way", 32'(bus.pred_way), 32'(expWay));
      clockEdge();
   endtask

   function automatic logic [31:0] rndPc();
      logic [31:0] t;
      t = ($urandom_range(0, 4) == 4) ? 32'h03FF_FFFF : 32'($urandom_range(0, 3));
      return (t << 6) | 32'($urandom_range(0, SETS - 1) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      nRST = 1'b0;
      bus.current_PC = 32'h100; bus.Wr_enable = 1'b0; bus.update_PC = '0;
      bus.update_target_PC = '0; bus.is_taken = 1'b0; bus.flush = 1'b0;
      modelReset();
      #1;
      checkOutput("rst_pc", bus.predicted_PC, 32'h104);
      checkOutput("rst_hit", 32'(bus.pred_hit), 32'd0);
      checkOutput("rst_taken", 32'(bus.pred_taken), 32'd0);
      checkOutput("rst_way", 32'(bus.pred_way), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Train, weaken, saturate.
      step(32'h100, 1, 32'h100, 32'h200, 1, 0);
      probe(32'h100, 32'h200, 1, 1, 0);
      step(32'h100, 1, 32'h100, 32'h200, 0, 0);
      probe(32'h100, 32'h104, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(32'h100, 1, 32'h100, 32'h200, 1, 0);
      step(32'h100, 1, 32'h100, 32'h200, 0, 0);
      probe(32'h100, 32'h200, 1, 1, 0);

      // Set-0 conflicts and round-robin eviction.
      step(32'h0, 1, 32'h140, 32'h240, 1, 0);
      step(32'h0, 1, 32'h180, 32'h280, 1, 0);
      probe(32'h100, 32'h104, 0, 0, 0);
      probe(32'h140, 32'h240, 1, 1, 1);
      probe(32'h180, 32'h280, 1, 1, 0);
      step(32'h0, 1, 32'h1C0, 32'h2C0, 1, 0);
      probe(32'h1C0, 32'h2C0, 1, 1, 1);
      probe(32'h140, 32'h144, 0, 0, 0);

      // Not-taken miss does not allocate.
      step(32'h0, 1, 32'h300, 32'h999, 0, 0);
      probe(32'h300, 32'h304, 0, 0, 0);

      // Flush beats a coincident update.
      step(32'h0, 1, 32'h400, 32'h500, 1, 1);
      probe(32'h400, 32'h404, 0, 0, 0);
      probe(32'h180, 32'h184, 0, 0, 0);
      probe(32'h1C0, 32'h1C4, 0, 0, 0);
      step(32'h0, 1, 32'h100, 32'h200, 1, 0);
      probe(32'h100, 32'h200, 1, 1, 0);

      // Randomized traffic with an asynchronous reset dropped in mid-update.
      for (int i = 0; i < 800; i++) begin
         if (i == 400) begin
            applyStimulus(rndPc(), 1, rndPc(), $urandom, 1, 0);
            #2 nRST = 1'b0;
            #1 modelReset();
            checkOutput("midrst_hit", 32'(bus.pred_hit), 32'd0);
            checkOutput("midrst_pc", bus.predicted_PC, bus.current_PC + 32'd4);
            @(posedge CLK);
            @(negedge CLK);
            nRST = 1'b1;
         end else begin
            step(rndPc(), $urandom_range(0, 3) != 0, rndPc(), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end
endmodule
